// File: rtl/axi_wr_slave_if.sv
// AXI write-path terminator for one SRAM-style slave: one AW at a time, each W beat
// becomes a single-cycle byte-enabled memory write, one B response per burst.
module axi_wr_slave_if #(
   parameter int ID_W   = 8,
   parameter int MEM_AW = 14
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic [ID_W-1:0]   AWID_S,
   input  logic [31:0]       AWADDR_S,
   input  logic [3:0]        AWLEN_S,
   input  logic [2:0]        AWSIZE_S,
   input  logic [1:0]        AWBURST_S,
   input  logic              AWVALID_S,
   output logic              AWREADY_S,
   input  logic [31:0]       WDATA_S,
   input  logic [3:0]        WSTRB_S,
   input  logic              WLAST_S,
   input  logic              WVALID_S,
   output logic              WREADY_S,
   output logic [ID_W-1:0]   BID_S,
   output logic [1:0]        BRESP_S,
   output logic              BVALID_S,
   input  logic              BREADY_S,
   output logic              MEM_CS,
   output logic [3:0]        MEM_WE,
   output logic [MEM_AW-1:0] MEM_A,
   output logic [31:0]       MEM_DI
);

   // state | meaning
   // IDLE  | waiting for an AW request
   // DATA  | absorbing W beats, one memory write per accepted beat
   // RESP  | holding B until BREADY_S
   typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [31:0]       addr_q, addr_d;
   logic [3:0]        len_q, len_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [1:0]        burst_q, burst_d;
   logic              err_q, err_d;
   logic              beat;
   logic              last_beat;
   logic              unused_addr;

   assign AWREADY_S = (state_q == IDLE);
   assign WREADY_S  = (state_q == DATA);
   assign BVALID_S  = (state_q == RESP);
   assign BID_S     = id_q;
   assign BRESP_S   = (state_q == RESP && err_q) ? 2'b10 : 2'b00;

   assign beat      = WVALID_S & WREADY_S;
   assign last_beat = (cnt_q == len_q);

   // Erroneous bursts still consume every beat, they just never write
   assign MEM_CS = beat;
   assign MEM_WE = (beat && !err_q) ? WSTRB_S : 4'h0;
   assign MEM_A  = addr_q[MEM_AW+1:2];
   assign MEM_DI = WDATA_S;

   assign unused_addr = ^{addr_q[31:MEM_AW+2], addr_q[1:0]};

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      addr_d  = addr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      burst_d = burst_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (AWVALID_S) begin
               id_d    = AWID_S;
               addr_d  = AWADDR_S;
               len_d   = AWLEN_S;
               burst_d = AWBURST_S;
               cnt_d   = 4'd0;
               err_d   = (AWSIZE_S != 3'b010) || AWBURST_S[1];
               state_d = DATA;
            end
         end
         DATA: begin
            if (WVALID_S) begin
               if (burst_q == 2'b01) addr_d = addr_q + 32'd4;
               cnt_d = cnt_q + 4'd1;
               if (WLAST_S != last_beat) err_d = 1'b1;
               // The beat count, not WLAST, ends the burst
               if (last_beat) state_d = RESP;
            end
         end
         RESP: begin
            if (BREADY_S) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= IDLE;
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         burst_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         burst_q <= burst_d;
         err_q   <= err_d;
      end
   end

endmodule
